alarma_uart_cmd: RTL

Command decoder that drives the alarm's setting interface from the UART receive path. It consumes ASCII bytes from the UART receiver and validates `AHH:MM<CR>` set commands and `X` cancel commands. For each valid set command it produces a one-cycle `load` pulse with stable `ore_setare`/`minute_setare`; for each cancel it produces a `stop` pulse. It sits between the UART byte receiver and the alarm block, and writes the values the alarm latches.

---
 rtl/alarma_uart_cmd_if.sv | 13 +
 rtl/alarma_uart_cmd.sv | 85 ++++++++
 2 files changed

// File: rtl/alarma_uart_cmd_if.sv
// alarma_uart_cmd_if: UART byte input and alarm setting outputs of the command decoder
interface alarma_uart_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       load;
  logic [4:0] ore_setare;
  logic [5:0] minute_setare;
  logic       stop;
  logic       err;
  logic       busy;
  modport master (output rx_data, rx_valid, input load, ore_setare, minute_setare, stop, err, busy);
  modport slave (input rx_data, rx_valid, output load, ore_setare, minute_setare, stop, err, busy);
endinterface

// File: rtl/alarma_uart_cmd.sv
// alarma_uart_cmd: decodes "AHH:MM<CR>" set and "X" cancel commands from the UART byte stream
module alarma_uart_cmd #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TO_WIDTH = 26
) (
  input logic clock,
  input logic reset,
  alarma_uart_cmd_if.slave bus
);
  typedef enum logic [2:0] {IDLE, H1, H2, COL, M1, M2, END} state_t;
  state_t state_q, state_d, nxt;
  logic [3:0] ht_q, ht_d, hu_q, hu_d, mt_q, mt_d, mu_q, mu_d;
  logic [4:0] ore_q, ore_d, hr;
  logic [5:0] min_q, min_d, mn;
  logic load_q, load_d, stop_q, stop_d, err_q, err_d, ok, timeout;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0] dg;
  assign dg = bus.rx_data - 8'h30;
  assign hr = (5'(ht_q) << 3) + (5'(ht_q) << 1) + 5'(hu_q);
  assign mn = (6'(mt_q) << 3) + (6'(mt_q) << 1) + 6'(mu_q);
  // counter is one behind the quiet-cycle count, so err lands TIMEOUT_CYCLES after the byte
  assign timeout = state_q != IDLE && !bus.rx_valid && cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 2);
  always_comb begin
    ok = 1'b1;
    nxt = IDLE;
    case (state_q)
      H1: begin ok = dg <= 8'd2; nxt = H2; end
      H2: begin ok = dg <= (ht_q == 4'd2 ? 8'd3 : 8'd9); nxt = COL; end
      COL: begin ok = bus.rx_data == 8'h3a; nxt = M1; end
      M1: begin ok = dg <= 8'd5; nxt = M2; end
      M2: begin ok = dg <= 8'd9; nxt = END; end
      END: ok = bus.rx_data == 8'h0d;
      default: nxt = bus.rx_data == 8'h41 ? H1 : IDLE;
    endcase
  end
  always_comb begin
    state_d = state_q;
    ht_d = ht_q;
    hu_d = hu_q;
    mt_d = mt_q;
    mu_d = mu_q;
    load_d = 1'b0;
    stop_d = 1'b0;
    err_d = 1'b0;
    cnt_d = bus.rx_valid || state_q == IDLE ? '0 : cnt_q + 1'b1;
    if (bus.rx_valid) begin
      state_d = ok ? nxt : IDLE;
      err_d = state_q != IDLE && !ok;
      stop_d = state_q == IDLE && bus.rx_data == 8'h58;
      load_d = state_q == END && ok;
      ht_d = state_q == H1 ? dg[3:0] : ht_q;
      hu_d = state_q == H2 ? dg[3:0] : hu_q;
      mt_d = state_q == M1 ? dg[3:0] : mt_q;
      mu_d = state_q == M2 ? dg[3:0] : mu_q;
    end else if (timeout) begin
      state_d = IDLE;
      err_d = 1'b1;
    end
    ore_d = load_d ? hr : ore_q;
    min_d = load_d ? mn : min_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      {ht_q, hu_q, mt_q, mu_q} <= '0;
      ore_q <= '0;
      min_q <= '0;
      {load_q, stop_q, err_q} <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      {ht_q, hu_q, mt_q, mu_q} <= {ht_d, hu_d, mt_d, mu_d};
      ore_q <= ore_d;
      min_q <= min_d;
      {load_q, stop_q, err_q} <= {load_d, stop_d, err_d};
      cnt_q <= cnt_d;
    end
  end
  assign bus.load = load_q;
  assign bus.stop = stop_q;
  assign bus.err = err_q;
  assign bus.busy = state_q != IDLE;
  assign bus.ore_setare = ore_q;
  assign bus.minute_setare = min_q;
endmodule
